// File: rtl/acia_txq.sv
// rtl/acia_txq.sv - Byte FIFO that drains one byte per ACIA transmit-empty handshake
module acia_txq #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic                       wr_i,
    input  logic [7:0]                 din_i,
    input  logic                       clr_ovf_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       idle_o,
    output logic                       acia_wr_o,
    output logic                       acia_rs_o,
    output logic [7:0]                 acia_dout_o,
    input  logic                       acia_txe_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_LO, S_WAIT_HI} state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          strobe_q, strobe_d;
    logic [7:0]    dout_q, dout_d;
    logic [2:0]    guard_q, guard_d;
    state_t        state_q, state_d;
    logic          full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // Full is judged on pre-edge state, so a same-cycle pop never rescues a push.
    assign push  = wr_i & ~full;

    always_comb begin
        state_d  = state_q;
        guard_d  = guard_q;
        strobe_d = 1'b0;
        dout_d   = dout_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && acia_txe_i) begin
                    pop      = 1'b1;
                    strobe_d = 1'b1;
                    dout_d   = mem_q[rd_ptr_q];
                    guard_d  = 3'd0;
                    state_d  = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                // Give up after 7 cycles so an ACIA held in reset cannot wedge the queue.
                if (!acia_txe_i) begin
                    guard_d = 3'd0;
                    state_d = S_WAIT_HI;
                end else if (guard_q == 3'd6) begin
                    guard_d = 3'd0;
                    state_d = S_IDLE;
                end else begin
                    guard_d = guard_q + 3'd1;
                end
            end
            S_WAIT_HI: begin
                if (acia_txe_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                guard_d = 3'd0;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_i && full) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            guard_q  <= 3'd0;
            strobe_q <= 1'b0;
            dout_q   <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            strobe_q <= strobe_d;
            dout_q   <= dout_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign full_o      = full;
    assign empty_o     = empty;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign idle_o      = empty & (state_q == S_IDLE) & acia_txe_i;
    assign acia_wr_o   = strobe_q;
    assign acia_rs_o   = strobe_q;
    assign acia_dout_o = dout_q;
endmodule

// File: tb/tb_acia_txq.sv
// tb/tb_acia_txq.sv - Directed bench for acia_txq with a small ACIA transmit-empty model
module tb_acia_txq;
    logic       clk = 1'b0;
    logic       rst_ni;
    logic       wr_i;
    logic [7:0] din_i;
    logic       clr_ovf_i;
    logic       full_o, empty_o, overflow_o, idle_o;
    logic [4:0] count_o;
    logic       acia_wr_o, acia_rs_o;
    logic [7:0] acia_dout_o;
    logic       acia_txe_i;

    int n_cmp = 0;
    int n_err = 0;

    logic txe_force = 1'b1;
    logic model_en  = 1'b0;
    logic model_txe = 1'b1;
    int   model_hold = 3;
    int   model_phase = 0;
    int   low_cnt = 0;
    logic txe_at_edge = 1'b1;
    logic prev_wr = 1'b0;
    int   strobe_cnt = 0;
    logic [7:0] got [$];

    assign acia_txe_i = model_en ? model_txe : txe_force;

    always #5 clk = ~clk;

    acia_txq #(.DEPTH(16)) dut (
        .clk(clk), .rst_ni(rst_ni), .wr_i(wr_i), .din_i(din_i), .clr_ovf_i(clr_ovf_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .overflow_o(overflow_o),
        .idle_o(idle_o), .acia_wr_o(acia_wr_o), .acia_rs_o(acia_rs_o),
        .acia_dout_o(acia_dout_o), .acia_txe_i(acia_txe_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ACIA model: txe drops two edges after it samples a strobe, stays low model_hold cycles.
    always @(negedge clk) begin
        if (!model_en) begin
            model_phase = 0;
            model_txe   = 1'b1;
        end else begin
            case (model_phase)
                0: if (acia_wr_o) model_phase = 1;
                1: begin model_txe = 1'b0; low_cnt = model_hold; model_phase = 2; end
                default: begin
                    if (low_cnt == 0) begin model_txe = 1'b1; model_phase = 0; end
                    else low_cnt--;
                end
            endcase
        end
    end

    always @(posedge clk) txe_at_edge <= acia_txe_i;

    always @(negedge clk) begin
        if (acia_wr_o) begin
            check("strobe_while_txe_low", {31'd0, txe_at_edge}, 32'd1);
            check("rs_equals_wr", {31'd0, acia_rs_o}, 32'd1);
            check("strobe_width", {31'd0, prev_wr}, 32'd0);
            got.push_back(acia_dout_o);
            strobe_cnt++;
        end
        prev_wr = acia_wr_o;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (idle_o && model_phase == 0) begin ok = 1'b1; break; end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int pushed;
        int guard;
        int snap;
        rst_ni = 1'b0; wr_i = 1'b0; din_i = 8'h00; clr_ovf_i = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        // Reset state
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_wr", acia_wr_o, 0);
        check("rst_rs", acia_rs_o, 0);
        check("rst_dout", acia_dout_o, 8'h00);
        check("rst_idle_txe1", idle_o, 1);
        txe_force = 1'b0; #1;
        check("rst_idle_txe0", idle_o, 0);
        txe_force = 1'b1;

        // Single byte latency
        model_hold = 3; model_en = 1'b1;
        tick();
        wr_i = 1'b1; din_i = 8'h41;
        tick();
        wr_i = 1'b0;
        check("t1_count_after_push", count_o, 1);
        check("t1_no_strobe_yet", acia_wr_o, 0);
        tick();
        check("t1_strobe", acia_wr_o, 1);
        check("t1_rs", acia_rs_o, 1);
        check("t1_dout", acia_dout_o, 8'h41);
        check("t1_count_zero", count_o, 0);
        tick();
        check("t1_strobe_dropped", acia_wr_o, 0);
        wait_idle(200, "t1_idle_timeout");
        check("t1_nbytes", got.size(), 1);

        // Slow ACIA, three back-to-back pushes
        got.delete();
        model_hold = 100;
        for (int i = 1; i <= 3; i++) begin
            wr_i = 1'b1; din_i = 8'(i);
            tick();
        end
        wr_i = 1'b0;
        wait_idle(1000, "t2_idle_timeout");
        check("t2_nbytes", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("t2_byte", got[i], i + 1);

        // Fill with txe low, 17th push overflows
        got.delete();
        model_en = 1'b0; txe_force = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_i = 1'b1; din_i = 8'h10 + 8'(i);
            tick();
        end
        wr_i = 1'b0;
        check("t3_full", full_o, 1);
        check("t3_count", count_o, 16);
        check("t3_ovf", overflow_o, 1);
        check("t3_idle", idle_o, 0);
        check("t3_no_output", got.size(), 0);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        check("t3_ovf_cleared", overflow_o, 0);
        check("t3_count_kept", count_o, 16);

        // Push and pop in the same cycle while full
        wr_i = 1'b1; din_i = 8'hAA; txe_force = 1'b1;
        tick();
        wr_i = 1'b0; txe_force = 1'b0;
        check("t4_count", count_o, 15);
        check("t4_ovf", overflow_o, 1);
        check("t4_full", full_o, 0);
        check("t4_strobe", acia_wr_o, 1);
        check("t4_dout", acia_dout_o, 8'h10);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;

        // Drain the rest: 0x20 and 0xAA must never appear
        model_hold = 2; model_en = 1'b1;
        wait_idle(2000, "t5a_idle_timeout");
        check("t5a_nbytes", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("t5a_byte", got[i], 8'h10 + i);

        // 20 bytes through a 16-deep queue with pointer wrap
        got.delete();
        pushed = 0; guard = 0;
        while (pushed < 20 && guard < 3000) begin
            if (!full_o) begin
                wr_i = 1'b1; din_i = 8'h80 + 8'(pushed); pushed++;
            end else begin
                wr_i = 1'b0;
            end
            tick();
            guard++;
        end
        wr_i = 1'b0;
        check("t5_push_timeout", pushed, 20);
        wait_idle(2000, "t5_idle_timeout");
        check("t5_nbytes", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++) check("t5_byte", got[i], 8'h80 + i);
        check("t5_idle", idle_o, 1);
        check("t5_count", count_o, 0);
        check("t5_ovf", overflow_o, 0);

        // Reset during WAIT_LO with 5 bytes queued
        model_en = 1'b0; txe_force = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_i = 1'b1; din_i = 8'hC0 + 8'(i);
            tick();
        end
        wr_i = 1'b1; din_i = 8'hC5; txe_force = 1'b1;
        tick();
        wr_i = 1'b0;
        check("t6_strobe_before_rst", acia_wr_o, 1);
        check("t6_dout_before_rst", acia_dout_o, 8'hC0);
        check("t6_count_before_rst", count_o, 5);
        rst_ni = 1'b0;
        #1;
        check("t6_wr_async", acia_wr_o, 0);
        check("t6_rs_async", acia_rs_o, 0);
        check("t6_count_async", count_o, 0);
        check("t6_empty_async", empty_o, 1);
        check("t6_dout_async", acia_dout_o, 8'h00);
        repeat (2) tick();
        rst_ni = 1'b1;
        snap = strobe_cnt;
        repeat (10) tick();
        check("t6_no_strobe_after_rst", strobe_cnt - snap, 0);

        // Guard timer: txe never drops, next byte still goes out
        got.delete();
        wr_i = 1'b1; din_i = 8'hD0;
        tick();
        din_i = 8'hD1;
        tick();
        wr_i = 1'b0;
        repeat (20) tick();
        check("t7_nbytes", got.size(), 2);
        if (got.size() == 2) begin
            check("t7_byte0", got[0], 8'hD0);
            check("t7_byte1", got[1], 8'hD1);
        end
        check("t7_idle", idle_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
